// File: rtl/vol_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vol_pio_pkg
// Description : Shared constants for the vol_ready_irq_pio input PIO.
//               Register word addresses and edge-type encodings.
// Revision    : 1.0  initial release
// ============================================================================
package vol_pio_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_COUNT   = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  // Qualifying-edge encodings for the EDGE_TYPE parameter
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage : vol_pio_pkg
`default_nettype wire

// File: rtl/vol_pio_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : vol_pio_edge_det
// Description : Input conditioning for the status PIO. Registers (or
//               double-flop synchronises) in_port into in_s, keeps a one-clock
//               delayed copy in_d and decodes the qualifying edge per bit.
//               Build option VOL_PIO_SYNC_EN selects the 2-flop synchroniser;
//               without it in_s is a single register of in_port.
// Ports       : clk, reset_n     clock, async active-low reset
//               in_port_i        raw status inputs
//               in_s_o           conditioned inputs (register data value)
//               edge_o           one-clock pulse per qualifying edge
// Revision    : 1.0  initial release
// ============================================================================
module vol_pio_edge_det
  import vol_pio_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port_i,
  output logic [WIDTH-1:0] in_s_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] in_s_q;
  logic [WIDTH-1:0] in_d_q;

`ifdef VOL_PIO_SYNC_EN
  // First stage may go metastable; only in_s_q is used by the logic.
  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      in_s_q <= '0;
    end else begin
      meta_q <= in_port_i;
      in_s_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_s_q <= '0;
    end else begin
      in_s_q <= in_port_i;
    end
  end
`endif

  // in_d resets to 0, so an input held high through reset yields one rising
  // edge just after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_d_q <= '0;
    end else begin
      in_d_q <= in_s_q;
    end
  end

  assign in_s_o = in_s_q;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_o = ~in_s_q & in_d_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_o = in_s_q ^ in_d_q;
    end else begin : g_rise
      assign edge_o = in_s_q & ~in_d_q;
    end
  endgenerate

endmodule : vol_pio_edge_det
`default_nettype wire

// File: rtl/vol_ready_irq_pio.sv
`default_nettype none
// ============================================================================
// Module      : vol_ready_irq_pio
// Description : Avalon-MM slave input PIO for datapath status strobes.
//               Captures qualifying edges of in_port into a W1C register,
//               keeps a saturating event count and raises a level irq when
//               an unmasked captured bit is set.
//               Build option VOL_PIO_SYNC_EN adds a 2-flop input synchroniser
//               (see vol_pio_edge_det); register map is identical either way.
// Ports       : clk, reset_n     clock, async active-low reset
//               address          word address (0 data, 1 count, 2 mask,
//                                3 edge capture)
//               chipselect, read_n, write_n, writedata   Avalon-MM slave
//               in_port          status inputs
//               readdata         registered read data, latency 1
//               irq              level interrupt, active high
// Revision    : 1.0  initial release
// ============================================================================
module vol_ready_irq_pio
  import vol_pio_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               EDGE_TYPE  = EDGE_RISE,
  parameter int               CNT_W      = 16,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             rd_stb;
  logic             wr_stb;
  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] edge_v;
  logic             any_edge;
  logic [WIDTH-1:0] clr;

  logic [WIDTH-1:0] cap_q,   cap_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  // Only the low WIDTH bits of writedata carry register content.
  logic             wdata_unused;
  assign wdata_unused = ^writedata;

  vol_pio_edge_det #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port_i (in_port),
    .in_s_o    (in_s),
    .edge_o    (edge_v)
  );

  assign rd_stb   = chipselect & ~read_n;
  assign wr_stb   = chipselect & ~write_n;
  assign any_edge = |edge_v;

  always_comb begin
    clr     = '0;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    if (wr_stb && (address == ADDR_CAPTURE)) begin
      clr = writedata[WIDTH-1:0];
    end
    // Edge ORed in after the clear: a coincident set wins.
    cap_d = edge_v | (cap_q & ~clr);

    if (wr_stb && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end

    // A clear that coincides with an event leaves the count at 1.
    if (wr_stb && (address == ADDR_COUNT)) begin
      cnt_d = any_edge ? CNT_W'(1) : '0;
    end else if (any_edge && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Read mux samples pre-update register values.
    if (rd_stb) begin
      rdata_d = '0;
      case (address)
        ADDR_DATA:    rdata_d[WIDTH-1:0] = in_s;
        ADDR_COUNT:   rdata_d[CNT_W-1:0] = cnt_q;
        ADDR_MASK:    rdata_d[WIDTH-1:0] = mask_q;
        ADDR_CAPTURE: rdata_d[WIDTH-1:0] = cap_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q   <= '0;
      mask_q  <= RESET_MASK;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule : vol_ready_irq_pio
`default_nettype wire

// File: tb/tb_vol_ready_irq_pio.sv
`default_nettype none
// ============================================================================
// Module      : tb_vol_ready_irq_pio
// Description : Self-checking bench for vol_ready_irq_pio. Two instances share
//               the bus and in_port: dut_a (rising edge, 4-bit counter) and
//               dut_b (any edge, 16-bit counter). A behavioural model of the
//               register map predicts readdata and irq every cycle; directed
//               steps add fixed expectations, then random traffic follows.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vol_ready_irq_pio;
  import vol_pio_pkg::*;

`ifdef VOL_PIO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vol_ready_irq_pio #(.WIDTH(4), .EDGE_TYPE(EDGE_RISE), .CNT_W(4), .RESET_MASK(4'h0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  vol_ready_irq_pio #(.WIDTH(4), .EDGE_TYPE(EDGE_ANY), .CNT_W(16), .RESET_MASK(4'h0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_b), .irq(irq_b)
  );

  // ---------------- reference model ----------------
  logic [3:0]  m_ins, m_ind, m_e, m_clr;
  logic [3:0]  m_dly[$];
  logic [3:0]  m_cap[2];
  logic [3:0]  m_mask[2];
  int unsigned m_cnt[2];
  logic [31:0] m_rd[2];

  function automatic logic [3:0] edges_of(int et, logic [3:0] now, logic [3:0] prev);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin
      if (et == 0)      e[i] = now[i] && !prev[i];
      else if (et == 1) e[i] = !now[i] && prev[i];
      else              e[i] = now[i] != prev[i];
    end
    return e;
  endfunction

  function automatic int unsigned cnt_max(int c);
    return (c == 0) ? 32'd15 : 32'd65535;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ins = 4'h0;
      m_ind = 4'h0;
      m_dly.delete();
      for (int k = 0; k < SYNC_LAT - 1; k++) m_dly.push_back(4'h0);
      for (int c = 0; c < 2; c++) begin
        m_cap[c]  = 4'h0;
        m_mask[c] = 4'h0;
        m_cnt[c]  = 0;
        m_rd[c]   = 32'h0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_e = edges_of((c == 0) ? 0 : 2, m_ins, m_ind);
        if (chipselect && !read_n) begin
          case (address)
            2'd0:    m_rd[c] = {28'h0, m_ins};
            2'd1:    m_rd[c] = m_cnt[c];
            2'd2:    m_rd[c] = {28'h0, m_mask[c]};
            default: m_rd[c] = {28'h0, m_cap[c]};
          endcase
        end
        m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_cap[c] = m_e | (m_cap[c] & ~m_clr);
        if (chipselect && !write_n && address == 2'd1)
          m_cnt[c] = (m_e != 0) ? 1 : 0;
        else if (m_e != 0 && m_cnt[c] < cnt_max(c))
          m_cnt[c] = m_cnt[c] + 1;
        if (chipselect && !write_n && address == 2'd2)
          m_mask[c] = writedata[3:0];
      end
      m_dly.push_back(in_port);
      m_ind = m_ins;
      m_ins = m_dly.pop_front();
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("model_rd_a", readdata_a, m_rd[0]);
    chk("model_rd_b", readdata_b, m_rd[1]);
    chk("model_irq_a", {31'h0, irq_a}, {31'h0, |(m_cap[0] & m_mask[0])});
    chk("model_irq_b", {31'h0, irq_b}, {31'h0, |(m_cap[1] & m_mask[1])});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] da, output logic [31:0] db);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    tick();
    chipselect = 1'b0; read_n = 1'b1;
    da = readdata_a; db = readdata_b;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] da, db;
  int lat_rd, lat_irq;

  initial begin
    // 1. Reset and input held high through it
    ticks(2);
    reset_n = 1'b1;
    ticks(4);
    bus_rd(ADDR_DATA, da, db);    chk("data_after_reset", da, 32'hF);
    bus_rd(ADDR_CAPTURE, da, db); chk("cap_post_reset_a", da, 32'hF);
                                  chk("cap_post_reset_b", db, 32'hF);
    bus_wr(ADDR_MASK, 32'hF);     chk("irq_mask_all", {31'h0, irq_a}, 32'd1);
    bus_rd(ADDR_DATA, da, db);
    // asynchronous reset in mid-cycle
    @(posedge clk); #3;
    reset_n = 1'b0; in_port = 4'h0;
    #1;
    chk("async_rst_rd_a", readdata_a, 32'h0);
    chk("async_rst_irq_a", {31'h0, irq_a}, 32'h0);
    chk("async_rst_rd_b", readdata_b, 32'h0);
    ticks(2);
    reset_n = 1'b1;
    ticks(4);
    bus_rd(ADDR_COUNT, da, db);   chk("cnt_reset", da, 32'h0);
    bus_rd(ADDR_CAPTURE, da, db); chk("cap_reset", da, 32'h0);
    bus_rd(ADDR_MASK, da, db);    chk("mask_reset", da, 32'h0);

    // 2. Rising edge on bit 0 with mask bit 0
    bus_wr(ADDR_MASK, 32'h1);
    in_port = 4'h1; tick(); in_port = 4'h0;
    ticks(SYNC_LAT + 1);
    chk("irq_rise", {31'h0, irq_a}, 32'd1);
    bus_rd(ADDR_CAPTURE, da, db); chk("cap_rise", da, 32'h1);
    bus_rd(ADDR_COUNT, da, db);   chk("cnt_rise", da, 32'h1);
    bus_wr(ADDR_CAPTURE, 32'h1);  chk("irq_after_w1c", {31'h0, irq_a}, 32'd0);
    bus_rd(ADDR_CAPTURE, da, db); chk("cap_after_w1c", da, 32'h0);

    // 3. Set/clear collisions
    in_port = 4'h4; ticks(SYNC_LAT);
    bus_wr(ADDR_CAPTURE, 32'h4);
    bus_rd(ADDR_CAPTURE, da, db); chk("collide_set_wins", da, 32'h4);
    in_port = 4'h6; ticks(SYNC_LAT);
    bus_wr(ADDR_CAPTURE, 32'h4);
    bus_rd(ADDR_CAPTURE, da, db); chk("collide_indep", da, 32'h2);
    in_port = 4'h0; ticks(4);
    bus_wr(ADDR_CAPTURE, 32'hF);

    // 4. Counter saturation (dut_a CNT_W=4) and clear-with-event
    bus_wr(ADDR_COUNT, 32'h0);
    for (int n = 0; n < 20; n++) begin
      in_port = 4'h1; ticks(2);
      in_port = 4'h0; ticks(2);
    end
    ticks(3);
    bus_rd(ADDR_COUNT, da, db);
    chk("cnt_saturate_a", da, 32'd15);
    chk("cnt_any_b", db, 32'd40);
    in_port = 4'h1; ticks(SYNC_LAT);
    bus_wr(ADDR_COUNT, 32'h0);
    bus_rd(ADDR_COUNT, da, db);
    chk("cnt_clr_event_a", da, 32'd1);
    chk("cnt_clr_event_b", db, 32'd1);
    in_port = 4'h0; ticks(4);
    bus_wr(ADDR_CAPTURE, 32'hF);

    // 5. Masking
    bus_wr(ADDR_MASK, 32'h0);
    in_port = 4'h8; ticks(SYNC_LAT + 2);
    chk("irq_masked", {31'h0, irq_a}, 32'd0);
    bus_rd(ADDR_CAPTURE, da, db); chk("cap_masked", da, 32'h8);
    bus_wr(ADDR_MASK, 32'h8);     chk("irq_unmask", {31'h0, irq_a}, 32'd1);
    in_port = 4'h0; ticks(4);
    bus_wr(ADDR_CAPTURE, 32'hF);
    bus_wr(ADDR_MASK, 32'h1);

    // 6. Latency from in_port to data readback and to capture (via irq)
    lat_rd = -1; lat_irq = -1;
    address = ADDR_DATA; chipselect = 1'b1; read_n = 1'b0;
    in_port = 4'h1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (lat_rd < 0 && readdata_a[0]) lat_rd = n;
      if (lat_irq < 0 && irq_a) lat_irq = n;
    end
    chipselect = 1'b0; read_n = 1'b1;
    chk("latency_data", 32'(lat_rd), 32'(SYNC_LAT + 1));
    chk("latency_cap", 32'(lat_irq), 32'(SYNC_LAT + 1));
    in_port = 4'h0; ticks(4);
    bus_wr(ADDR_COUNT, 32'h0);
    in_port = 4'h2; ticks(3);
    in_port = 4'h0; ticks(4);
    bus_rd(ADDR_COUNT, da, db);
    chk("toggle_pair_any_b", db, 32'd2);
    chk("toggle_pair_rise_a", da, 32'd1);

    // Random traffic checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      in_port = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       tick();
        1:       bus_rd(2'($urandom), da, db);
        2:       bus_wr(2'($urandom), $urandom);
        default: begin
          in_port = 4'($urandom);
          tick();
        end
      endcase
    end
    ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vol_ready_irq_pio
`default_nettype wire
